// File: rtl/camera_emu_pkg.sv
// Shared types and constants for the camera frame emulator.
package camera_emu_pkg;

  // Frame sequencing states: waiting for a burst, inside a burst, counting down to INT.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DELAY = 2'd2
  } emu_state_t;

  // Burst-end to interrupt delay: real hardware at 240 MHz, and a short one for simulation.
  localparam int INT_DELAY_HW  = 239980;
  localparam int INT_DELAY_SIM = 240;

  // Quiet CLK cycles on SCLK before a burst is considered finished.
  localparam int IDLE_CYCLES_DEFAULT = 64;

  // Width of a counter that must hold 0 .. period-1 (at least one bit).
  function automatic int phase_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/sclk_activity_detector.sv
// Synchronises the host SPI clock into the CLK domain and turns its
// activity into burst start / burst end pulses.
module sclk_activity_detector
  import camera_emu_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SCLK,
  output logic EDGE,
  output logic BUSY,
  output logic START,
  output logic END
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s;
  logic                   edge_det;
  logic                   busy_q;
  logic                   idle_done;
  logic [CNT_W-1:0]       idle_cnt_q;

  assign sclk_s    = sync_q[SYNC_STAGES-1];
  assign edge_det  = sclk_s ^ sclk_prev_q;
  assign idle_done = busy_q && !edge_det && (idle_cnt_q == IDLE_LAST);

  // Shift SCLK through the synchroniser chain and remember the last synchronised level.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], SCLK};
      sclk_prev_q <= sclk_s;
    end
  end

  // Track burst activity: every edge restarts the quiet-time count, and the
  // burst ends once IDLE_CYCLES cycles have passed without an edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      busy_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else if (edge_det) begin
      busy_q     <= 1'b1;
      idle_cnt_q <= '0;
    end else if (idle_done) begin
      busy_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else if (busy_q) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign EDGE  = edge_det;
  assign BUSY  = busy_q;
  assign START = edge_det && !busy_q;
  assign END   = idle_done;

endmodule

// File: rtl/camera_frame_emulator.sv
// Camera-side emulator: detects host readout bursts on SCLK, counts frames,
// raises LOOKUP every LOOKUP_PERIOD-th frame and a delayed frame-ready INT.
module camera_frame_emulator
  import camera_emu_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int IDLE_CYCLES   = IDLE_CYCLES_DEFAULT,
  parameter bit D_SIM         = 1'b0,
  parameter int INT_DELAY     = D_SIM ? INT_DELAY_SIM : INT_DELAY_HW,
  parameter int CNT_W         = 32,
  parameter int LOOKUP_PERIOD = 2,
  parameter int FCNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SCLK,
  input  logic              INT_ACK,
  output logic              BUSY,
  output logic              INT,
  output logic              LOOKUP,
  output logic              OVERRUN,
  output logic [FCNT_W-1:0] FRAME_CNT,
  output logic              LED_R,
  output logic              LED_G,
  output logic              LED_B
);

  localparam int               PH_W       = phase_width(LOOKUP_PERIOD);
  localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(LOOKUP_PERIOD - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(INT_DELAY - 1);

  logic sclk_edge;
  logic sclk_busy;
  logic burst_start;
  logic burst_end;

  emu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  delay_q, delay_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              int_q, int_d;
  logic              lookup_q, lookup_d;
  logic              overrun_q, overrun_d;

  sclk_activity_detector #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_CYCLES (IDLE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_detector (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SCLK  (SCLK),
    .EDGE  (sclk_edge),
    .BUSY  (sclk_busy),
    .START (burst_start),
    .END   (burst_end)
  );

  // Register the FSM state together with all frame bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      phase_q   <= '0;
      fcnt_q    <= '0;
      int_q     <= 1'b0;
      lookup_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      phase_q   <= phase_d;
      fcnt_q    <= fcnt_d;
      int_q     <= int_d;
      lookup_q  <= lookup_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic. An acknowledge clears INT first so that a set in the
  // same cycle overrides it; a new burst always clears INT and LOOKUP, and an
  // edge while the delay is still counting aborts that frame's interrupt.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    phase_d   = phase_q;
    fcnt_d    = fcnt_q;
    int_d     = int_q;
    lookup_d  = lookup_q;
    overrun_d = overrun_q;

    if (INT_ACK) begin
      int_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        delay_d = '0;
        if (burst_start) begin
          state_d  = BURST;
          int_d    = 1'b0;
          lookup_d = 1'b0;
        end
      end

      BURST: begin
        delay_d = '0;
        if (burst_end) begin
          state_d  = DELAY;
          fcnt_d   = fcnt_q + 1'b1;
          lookup_d = (phase_q == PHASE_LAST);
          phase_d  = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        end
      end

      DELAY: begin
        if (sclk_edge) begin
          state_d   = BURST;
          overrun_d = 1'b1;
          int_d     = 1'b0;
          lookup_d  = 1'b0;
          delay_d   = '0;
        end else if (delay_q == DELAY_LAST) begin
          state_d = IDLE;
          int_d   = 1'b1;
          delay_d = '0;
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        delay_d = '0;
      end
    endcase
  end

  assign BUSY      = sclk_busy;
  assign INT       = int_q;
  assign LOOKUP    = lookup_q;
  assign OVERRUN   = overrun_q;
  assign FRAME_CNT = fcnt_q;
  assign LED_R     = ~int_q;
  assign LED_G     = ~lookup_q;
  assign LED_B     = ~sclk_busy;

endmodule

// File: doc/camera_frame_emulator.md
Name: camera_frame_emulator

Overview:
- Parametrised camera-side emulator for the 64x64 sensor test rig.
- Watches the host SPI clock (SCLK) and detects each readout burst.
- Signals the host with a LOOKUP strobe on every LOOKUP_PERIOD-th frame, and raises a frame-ready interrupt INT_DELAY cycles after each burst ends.
- Adds frame counting, interrupt acknowledge and overrun detection, and runs on the PLL core clock.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on SCLK (must be >= 2).
- IDLE_CYCLES, 64: CLK cycles with no SCLK edge before a burst counts as ended (must be >= 2).
- INT_DELAY, 239980: CLK cycles from burst end to INT assertion (must be >= 1); 240 in simulation.
- CNT_W, 32: width of the delay and idle counters (must hold both IDLE_CYCLES and INT_DELAY).
- LOOKUP_PERIOD, 2: LOOKUP is raised after every LOOKUP_PERIOD-th burst (1 means every burst).
- FCNT_W, 16: width of the frame counter.

Ports:
- CLK  in  1  core clock (240 MHz from PLL12M).
- RST_N  in  1  synchronous active-low reset.
- SCLK  in  1  host SPI clock, asynchronous to CLK.
- INT_ACK  in  1  single-cycle pulse from the host; clears INT.
- BUSY  out  1  SPI burst in progress.
- INT  out  1  frame-ready interrupt, level, held until cleared.
- LOOKUP  out  1  lookup flag for the most recent burst.
- OVERRUN  out  1  sticky: a burst started while the INT delay was still pending.
- FRAME_CNT  out  FCNT_W  count of completed bursts; wraps modulo 2^FCNT_W.
- LED_R / LED_G / LED_B  out  1  active-low copies of INT / LOOKUP / BUSY.

Behaviour:
- Reset (RST_N low at a CLK rising edge):
  - All state is cleared, the FSM goes to IDLE and the lookup phase counter goes to 0.
  - BUSY, INT, LOOKUP and OVERRUN are 0; FRAME_CNT is 0; all LEDs are 1.
  - Reset overrides every other event, including reset mid-burst or mid-delay.
- SCLK handling: SCLK passes through SYNC_STAGES flops. An "edge" is any change of the synchronised value.
- FSM states: IDLE, BURST, DELAY.
- IDLE:
  - On an edge: go to BURST next cycle, BUSY=1, INT=0, LOOKUP=0.
- BURST:
  - The idle counter clears on every edge and otherwise increments.
  - When it reaches IDLE_CYCLES-1 with no edge:
    - BUSY=0, go to DELAY.
    - FRAME_CNT increments.
    - LOOKUP is set to (phase == LOOKUP_PERIOD-1).
    - Phase increments, wrapping to 0 at LOOKUP_PERIOD.
  - Result: BUSY falls exactly IDLE_CYCLES cycles after the last synchronised edge.
- DELAY:
  - The delay counter starts at 0 on entry.
  - INT rises exactly INT_DELAY cycles after BUSY falls, then the FSM returns to IDLE.
  - An edge during DELAY sets OVERRUN=1, aborts the delay (INT is not asserted for that frame), and moves to BURST with LOOKUP=0. FRAME_CNT is already counted.
- INT clearing:
  - INT clears on INT_ACK, or on the next burst start.
  - If INT_ACK arrives in the same cycle INT is being set, the set wins.
  - INT_ACK while INT=0 has no effect.
- LOOKUP holds its value until the next burst starts.
- OVERRUN clears only on reset.
- A burst start arriving while INT=1 (host never acked) is not an overrun; INT simply clears.
- Counters never exceed their terminal values; FRAME_CNT wraps from all-ones to 0 silently.

Decomposition:
- Package camera_emu_pkg holds:
  - the state enum (IDLE, BURST, DELAY);
  - constants INT_DELAY_HW = 239980 and INT_DELAY_SIM = 240;
  - the default IDLE_CYCLES.
- The top level selects the delay constant via D_SIM.
- Sub-module sclk_activity_detector (parameters SYNC_STAGES, IDLE_CYCLES, CNT_W):
  - contains the synchroniser, edge detect and idle counter;
  - outputs EDGE (1-cycle pulse), BUSY, START pulse and END pulse.
- The top level contains the FSM, delay counter, phase counter, frame counter and outputs.

Test Plan:
Bench parameters: IDLE_CYCLES=8, INT_DELAY=16, LOOKUP_PERIOD=3, FCNT_W=4.
- Reset then idle: hold RST_N low 4 cycles, SCLK static for 100 cycles -> all outputs 0, LEDs 1, FRAME_CNT=0.
- Single burst: 10 SCLK toggles -> BUSY rises, then falls 8 cycles after the last synchronised edge; FRAME_CNT=1, LOOKUP=0; INT rises exactly 16 cycles after BUSY falls; INT_ACK one cycle later -> INT=0.
- Lookup cadence: 6 well-spaced bursts -> LOOKUP=1 only after bursts 3 and 6; LOOKUP clears at the start of each following burst.
- Overrun: start a burst 5 cycles after BUSY falls -> OVERRUN=1 and stays 1, no INT for that frame, INT for the next frame arrives normally.
- Ack collision and wrap: INT_ACK pulsed in the cycle INT is set -> INT=1. 17 bursts -> FRAME_CNT=1.
- Reset mid-DELAY: RST_N low 8 cycles after BUSY falls -> INT never asserts, all outputs 0, the next burst behaves as the first (LOOKUP only after the 3rd burst).
